// File: rtl/multicycle_main_fsm_pkg.sv
// arm_ctrl_pkg: shared encodings for the multicycle ARM main controller.
//   state_t  : 4-bit controller state, codes fixed (FETCH=0 .. BRANCH=9)
//   OP_*     : instr[27:26] major opcode classes
//   ALU_SRC_A_* / ALU_SRC_B_* / RESULT_SRC_* : datapath mux selects
//   ctrl_t   : bundle of raw control outputs produced per state
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN (memory wait handshake).
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] ALU_SRC_A_RN = 2'b00;
    localparam logic [1:0] ALU_SRC_A_PC = 2'b01;

    localparam logic [1:0] ALU_SRC_B_RM   = 2'b00;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RESULT_SRC_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_SRC_RDATA  = 2'b01;
    localparam logic [1:0] RESULT_SRC_ALU    = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       next_pc;
        logic       branch;
        logic       reg_w;
        logic       mem_w;
        logic       undef;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// multicycle_main_fsm_if: controller <-> datapath/CondLogic signal bundle.
//   op, funct, mem_ready (only with MULTICYCLE_MEM_WAIT_EN) : into controller
//   ir_write .. undef, state                                 : out of controller
// modport master = controller side, slave = datapath side.
interface multicycle_main_fsm_if;
    logic [1:0] op;
    logic [5:0] funct;
`ifdef MULTICYCLE_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       undef;
    logic [3:0] state;

    modport master (
        input  op, funct,
`ifdef MULTICYCLE_MEM_WAIT_EN
        input  mem_ready,
`endif
        output ir_write, adr_src, alu_src_a, alu_src_b, result_src,
        output alu_op, next_pc, branch, reg_w, mem_w, undef, state
    );

    modport slave (
        output op, funct,
`ifdef MULTICYCLE_MEM_WAIT_EN
        output mem_ready,
`endif
        input  ir_write, adr_src, alu_src_a, alu_src_b, result_src,
        input  alu_op, next_pc, branch, reg_w, mem_w, undef, state
    );
endinterface

// File: rtl/multicycle_main_fsm_decode.sv
// fsm_output_decode: combinational state -> raw control outputs.
//   state     in  current controller state
//   op        in  major opcode (only for the undef pulse in DECODE)
//   mem_ready in  memory handshake (only with MULTICYCLE_MEM_WAIT_EN)
//   ctrl      out control bundle (ungated by reset)
import arm_ctrl_pkg::*;

module fsm_output_decode (
    input  state_t     state,
    input  logic [1:0] op,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output ctrl_t      ctrl
);
    logic fetch_go;

`ifdef MULTICYCLE_MEM_WAIT_EN
    // PC increment / IR load only on the cycle the fetch actually completes,
    // so a stalled fetch cannot bump the PC more than once.
    assign fetch_go = mem_ready;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.ir_write   = fetch_go;
                ctrl.next_pc    = fetch_go;
                ctrl.alu_src_a  = ALU_SRC_A_PC;
                ctrl.alu_src_b  = ALU_SRC_B_FOUR;
                ctrl.result_src = RESULT_SRC_ALU;
            end
            DECODE: begin
                // PC+4 again gives PC+8 for R15 operand reads
                ctrl.alu_src_a  = ALU_SRC_A_PC;
                ctrl.alu_src_b  = ALU_SRC_B_FOUR;
                ctrl.result_src = RESULT_SRC_ALU;
                ctrl.undef      = (op == OP_UNDEF);
            end
            MEMADR: ctrl.alu_src_b = ALU_SRC_B_IMM;
            MEMRD:  ctrl.adr_src   = 1'b1;
            MEMWB: begin
                ctrl.result_src = RESULT_SRC_RDATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            EXECR:  ctrl.alu_op = 1'b1;
            EXECI: begin
                ctrl.alu_op    = 1'b1;
                ctrl.alu_src_b = ALU_SRC_B_IMM;
            end
            ALUWB:  ctrl.reg_w = 1'b1;
            BRANCH: begin
                ctrl.alu_src_b  = ALU_SRC_B_IMM;
                ctrl.result_src = RESULT_SRC_ALU;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main Moore controller of the multicycle ARM core.
// Sequences fetch/decode/execute/writeback; raw requests go to CondLogic.
//   clk     in  rising-edge clock
//   reset_n in  asynchronous active-low reset; all outputs 0 while low
//   bus     master modport of multicycle_main_fsm_if (op/funct in,
//           datapath selects, reg_w/mem_w/next_pc/branch/undef/state out)
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN -- FETCH/MEMRD/MEMWR
// hold until mem_ready=1.
import arm_ctrl_pkg::*;

module multicycle_main_fsm (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_main_fsm_if.master  bus
);
    state_t state_q, state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;
    logic   mem_go;
    logic   unused_funct;

    assign unused_funct = ^bus.funct[4:1];

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = mem_go ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_DP:   state_d = bus.funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = bus.funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_go ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_go ? FETCH : MEMWR;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    fsm_output_decode u_dec (
        .state     (state_q),
        .op        (bus.op),
`ifdef MULTICYCLE_MEM_WAIT_EN
        .mem_ready (bus.mem_ready),
`endif
        .ctrl      (ctrl)
    );

    // Gate combinationally so nothing leaks while reset is held, even before
    // the first clock edge.
    assign ctrl_g = reset_n ? ctrl : '0;

    assign bus.ir_write   = ctrl_g.ir_write;
    assign bus.adr_src    = ctrl_g.adr_src;
    assign bus.alu_src_a  = ctrl_g.alu_src_a;
    assign bus.alu_src_b  = ctrl_g.alu_src_b;
    assign bus.result_src = ctrl_g.result_src;
    assign bus.alu_op     = ctrl_g.alu_op;
    assign bus.next_pc    = ctrl_g.next_pc;
    assign bus.branch     = ctrl_g.branch;
    assign bus.reg_w      = ctrl_g.reg_w;
    assign bus.mem_w      = ctrl_g.mem_w;
    assign bus.undef      = ctrl_g.undef;
    assign bus.state      = reset_n ? state_q : 4'd0;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm: directed instruction sequences with
// hand-written per-state expected outputs, checked through a scoreboard.
// Optional feature macro: MULTICYCLE_MEM_WAIT_EN enables the wait-state test.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Expected control vector per state:
    // {ir_write, adr_src, alu_src_a[1:0], alu_src_b[1:0], result_src[1:0],
    //  alu_op, next_pc, branch, reg_w, mem_w, undef}
    localparam logic [13:0] EXP_OUT [0:9] = '{
        14'b1_0_01_10_10_0_1_0_0_0_0,   // FETCH
        14'b0_0_01_10_10_0_0_0_0_0_0,   // DECODE
        14'b0_0_00_01_00_0_0_0_0_0_0,   // MEMADR
        14'b0_1_00_00_00_0_0_0_0_0_0,   // MEMRD
        14'b0_0_00_00_01_0_0_0_1_0_0,   // MEMWB
        14'b0_1_00_00_00_0_0_0_0_1_0,   // MEMWR
        14'b0_0_00_00_00_1_0_0_0_0_0,   // EXECR
        14'b0_0_00_01_00_1_0_0_0_0_0,   // EXECI
        14'b0_0_00_00_00_0_0_0_1_0_0,   // ALUWB
        14'b0_0_00_01_10_0_0_1_0_0_0    // BRANCH
    };
    localparam logic [13:0] FETCH_STALL_MASK = 14'h2010; // ir_write | next_pc

    typedef struct {
        logic [17:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    logic [17:0] obs;
    assign obs = {bus.state, bus.ir_write, bus.adr_src, bus.alu_src_a,
                  bus.alu_src_b, bus.result_src, bus.alu_op, bus.next_pc,
                  bus.branch, bus.reg_w, bus.mem_w, bus.undef};

    // Monitor: the controller presents a full output vector every cycle;
    // compare whenever an expectation is waiting.
    exp_t cur;
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                checks++;
                if (obs !== cur.v) begin
                    errors++;
                    $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                             cur.nm, obs[17:14], obs[13:0], cur.v[17:14], cur.v[13:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_raw(input logic [17:0] v, input string nm);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic push_st(input logic [3:0] st, input logic und, input string nm);
        push_raw({st, EXP_OUT[st] | {13'b0, und}}, nm);
    endtask

    // Drive op/funct while in FETCH, then expect the given state sequence
    // (first state in the top nibble) over the next n cycles.
    task automatic run(input logic [1:0] op, input logic [5:0] funct,
                       input logic [23:0] seq, input int n, input string nm);
        logic [3:0] st;
        bus.op    = op;
        bus.funct = funct;
        for (int i = 0; i < n; i++) begin
            tick();
            st = seq[23-4*i -: 4];
            push_st(st, (op == 2'b11) && (st == 4'd1), nm);
        end
    endtask

    task automatic fetch(input string nm);
        tick();
        push_st(4'd0, 1'b0, nm);
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.op    = 2'b00;
        bus.funct = 6'b000000;
`ifdef MULTICYCLE_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        // reset held two cycles: everything zero
        tick(); push_raw(18'd0, "reset_c0");
        tick(); push_raw(18'd0, "reset_c1");
        tick(); reset_n = 1'b1; push_st(4'd0, 1'b0, "reset_release_fetch");

        run(2'b00, 6'b000100, 24'h168000, 3, "dp_reg");  fetch("dp_reg_end");
        run(2'b00, 6'b100100, 24'h178000, 3, "dp_imm");  fetch("dp_imm_end");
        run(2'b01, 6'b011001, 24'h123400, 4, "ldr");     fetch("ldr_end");
        run(2'b01, 6'b011000, 24'h125000, 3, "str");     fetch("str_end");
        run(2'b10, 6'b100000, 24'h190000, 2, "b");       fetch("b_end");
        run(2'b11, 6'b000000, 24'h100000, 1, "undef");   fetch("undef_end");

        // async reset between edges in MEMRD
        run(2'b01, 6'b011001, 24'h123000, 3, "ldr_abort");
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        push_raw(18'd0, "reset_mid_memrd");
        -> sample_ev;
        tick(); push_raw(18'd0, "reset_hold_no_memwb");
        tick(); reset_n = 1'b1; push_st(4'd0, 1'b0, "reset_release2");

        run(2'b00, 6'b000100, 24'h168000, 3, "dp_after_reset");

`ifdef MULTICYCLE_MEM_WAIT_EN
        // fetch stalled three cycles: no IR load / PC bump until ready
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.mem_ready = 1'b0;
            push_raw({4'd0, EXP_OUT[0] & ~FETCH_STALL_MASK}, "fetch_stall");
        end
        tick(); bus.mem_ready = 1'b1; push_st(4'd0, 1'b0, "fetch_ready");
        // STR with two wait cycles in MEMWR
        run(2'b01, 6'b011000, 24'h120000, 2, "str_wait");
        tick(); bus.mem_ready = 1'b0; push_st(4'd5, 1'b0, "memwr_wait0");
        tick();                       push_st(4'd5, 1'b0, "memwr_wait1");
        tick(); bus.mem_ready = 1'b1; push_st(4'd5, 1'b0, "memwr_done");
        fetch("str_wait_end");
`else
        fetch("dp_after_reset_end");
`endif

        // let the monitor drain, bounded
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
